// File: rtl/hack_cpu_mc.sv
// rtl/hack_cpu_mc.sv - multi-cycle Hack-ISA CPU core with ready/valid memory ports
//
// Purpose:
//   Executes Hack instructions over several cycles (FETCH, EXEC, MEM_RD,
//   MEM_WR, WB) so slow instruction ROM and data RAM/MMIO can stall the core
//   through instr_valid and mem_ready instead of needing single-cycle memory.
//
// Parameters:
//   DATA_W   width of A, D, ALU and data bus (>= 16)
//   ADDR_W   width of pc_ and addressM (<= DATA_W, low bits of A)
//   RESET_PC PC value loaded on reset
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous, active-high; aborts any instruction in flight
//   instruction  instruction word from ROM, sampled only in FETCH
//   instr_valid  instruction is valid for pc_
//   pc_          instruction fetch address
//   instr_req    fetch request
//   inM          read data, sampled only in MEM_RD
//   mem_ready    read data valid / write accepted
//   readM        data read request (registered)
//   writeM       data write request (registered)
//   addressM     data address, low ADDR_W bits of A
//   outM         write data, registered ALU result
//   instret      retired-instruction counter (only with HACK_CPU_PERF_EN)
//
// Build option:
//   HACK_CPU_PERF_EN  adds the 32-bit instret output and its counter.

module hack_cpu_mc #(
   parameter int          DATA_W   = 16,
   parameter int          ADDR_W   = 15,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       instruction,
   input  logic              instr_valid,
   output logic [ADDR_W-1:0] pc_,
   output logic              instr_req,
   input  logic [DATA_W-1:0] inM,
   input  logic              mem_ready,
   output logic              readM,
   output logic              writeM,
   output logic [ADDR_W-1:0] addressM,
   output logic [DATA_W-1:0] outM
`ifdef HACK_CPU_PERF_EN
   ,
   output logic [31:0]       instret
`else
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_EXEC   = 3'd1,
      S_MEM_RD = 3'd2,
      S_MEM_WR = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [ADDR_W-1:0]   pc_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   d_q;
   logic [15:0]         ir_q;
   logic [DATA_W-1:0]   res_q;
   logic                instr_q;
   logic                read_q;
   logic                write_q;

   // instruction field decode
   logic                is_c;
   logic                use_m;
   logic                dest_a;
   logic                dest_d;
   logic                dest_m;
   logic [DATA_W-1:0]   a_imm;
   logic [ADDR_W-1:0]   pc_inc;

   // ALU datapath
   logic [DATA_W-1:0]   alu_x0;
   logic [DATA_W-1:0]   alu_x1;
   logic [DATA_W-1:0]   alu_y_src;
   logic [DATA_W-1:0]   alu_y0;
   logic [DATA_W-1:0]   alu_y1;
   logic [DATA_W-1:0]   alu_f;
   logic [DATA_W-1:0]   alu_out;

   // flags are taken from the registered result so WB decides the jump
   // from exactly the value that was (or will be) written
   logic                res_zr;
   logic                res_ng;
   logic                jump;

   logic                fetch_fire;
   logic                retire;

   assign is_c   = ir_q[15];
   assign use_m  = ir_q[12];
   assign dest_a = ir_q[5];
   assign dest_d = ir_q[4];
   assign dest_m = ir_q[3];
   assign a_imm  = DATA_W'(ir_q[14:0]);
   assign pc_inc = pc_q + ADDR_W'(1);

   // instr_q is low for the first cycle after reset, so no instruction is
   // taken until the fetch request is actually visible on instr_req
   assign fetch_fire = (state_q == S_FETCH) && instr_q && instr_valid;

   assign res_zr = (res_q == '0);
   assign res_ng = res_q[DATA_W-1];
   assign jump   = (ir_q[2] & res_ng) |
                   (ir_q[1] & res_zr) |
                   (ir_q[0] & ~res_ng & ~res_zr);

   always_comb begin
      alu_x0    = d_q;
      alu_x1    = d_q;
      alu_y_src = a_q;
      alu_y0    = a_q;
      alu_y1    = a_q;
      alu_f     = '0;
      alu_out   = '0;

      // the y operand is the memory word only while the read is in progress
      if (state_q == S_MEM_RD) begin
         alu_y_src = inM;
      end

      alu_x0  = ir_q[11] ? '0 : d_q;
      alu_x1  = ir_q[10] ? ~alu_x0 : alu_x0;
      alu_y0  = ir_q[9]  ? '0 : alu_y_src;
      alu_y1  = ir_q[8]  ? ~alu_y0 : alu_y0;
      alu_f   = ir_q[7]  ? (alu_x1 + alu_y1) : (alu_x1 & alu_y1);
      alu_out = ir_q[6]  ? ~alu_f : alu_f;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH: begin
            if (fetch_fire) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!is_c) begin
               state_d = S_FETCH;
            end else if (use_m) begin
               state_d = S_MEM_RD;
            end else if (dest_m) begin
               state_d = S_MEM_WR;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM_RD: begin
            if (mem_ready) begin
               state_d = dest_m ? S_MEM_WR : S_WB;
            end
         end
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign retire = ((state_q == S_EXEC) && !is_c) || (state_q == S_WB);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= ADDR_W'(RESET_PC);
         a_q     <= '0;
         d_q     <= '0;
         ir_q    <= '0;
         res_q   <= '0;
         instr_q <= 1'b0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;

         // handshake strobes are registered copies of the next state so they
         // never glitch and readM/writeM can never overlap
         instr_q <= (state_d == S_FETCH);
         read_q  <= (state_d == S_MEM_RD);
         write_q <= (state_d == S_MEM_WR);

         unique case (state_q)
            S_FETCH: begin
               if (fetch_fire) begin
                  ir_q <= instruction;
               end
            end
            S_EXEC: begin
               if (!is_c) begin
                  a_q  <= a_imm;
                  pc_q <= pc_inc;
               end else if (!use_m) begin
                  res_q <= alu_out;
               end
            end
            S_MEM_RD: begin
               if (mem_ready) begin
                  res_q <= alu_out;
               end
            end
            S_MEM_WR: begin
            end
            S_WB: begin
               // a_q on the right-hand side is still the pre-instruction A,
               // which is what the jump target must use
               if (dest_a) begin
                  a_q <= res_q;
               end
               if (dest_d) begin
                  d_q <= res_q;
               end
               pc_q <= jump ? a_q[ADDR_W-1:0] : pc_inc;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef HACK_CPU_PERF_EN
   logic [31:0] instret_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;
`else
   logic unused_retire;
   assign unused_retire = retire;
`endif

   assign pc_       = pc_q;
   assign instr_req = instr_q;
   assign readM     = read_q;
   assign writeM    = write_q;
   assign addressM  = a_q[ADDR_W-1:0];
   assign outM      = res_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb/tb_hack_cpu_mc.sv - scoreboard bench for hack_cpu_mc with ROM/RAM models

module tb_hack_cpu_mc;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 15;

   // Hack comp fields (c1..c6)
   localparam logic [5:0] C_ZERO = 6'b101010;
   localparam logic [5:0] C_M1   = 6'b111010;
   localparam logic [5:0] C_D    = 6'b001100;
   localparam logic [5:0] C_A    = 6'b110000;
   localparam logic [5:0] C_DP1  = 6'b011111;
   localparam logic [5:0] C_AP1  = 6'b110111;
   localparam logic [5:0] C_AM1  = 6'b110010;
   localparam logic [5:0] C_DPA  = 6'b000010;

   logic              clock;
   logic              reset;
   logic [15:0]       instruction;
   logic              instr_valid;
   logic [ADDR_W-1:0] pc_;
   logic              instr_req;
   logic [DATA_W-1:0] inM;
   logic              mem_ready;
   logic              readM;
   logic              writeM;
   logic [ADDR_W-1:0] addressM;
   logic [DATA_W-1:0] outM;
`ifdef HACK_CPU_PERF_EN
   logic [31:0]       instret;
`endif

   hack_cpu_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
      .clock       (clock),
      .reset       (reset),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pc_         (pc_),
      .instr_req   (instr_req),
      .inM         (inM),
      .mem_ready   (mem_ready),
      .readM       (readM),
      .writeM      (writeM),
      .addressM    (addressM),
      .outM        (outM)
`ifdef HACK_CPU_PERF_EN
      ,
      .instret     (instret)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ROM / RAM models
   logic [15:0] rom [0:63];
   logic [15:0] ram [0:63];
   int          rd_wait;
   int          wr_wait;
   int          rd_cnt;
   int          wr_cnt;

   assign instruction = rom[pc_[5:0]];
   assign instr_valid = instr_req;
   assign inM         = ram[addressM[5:0]];
   assign mem_ready   = (readM && (rd_cnt >= rd_wait)) || (writeM && (wr_cnt >= wr_wait));

   always @(posedge clock) begin
      if (readM && !mem_ready) rd_cnt <= rd_cnt + 1;
      else                     rd_cnt <= 0;
      if (writeM && !mem_ready) wr_cnt <= wr_cnt + 1;
      else                      wr_cnt <= 0;
      if (writeM && mem_ready) ram[addressM[5:0]] <= outM;
   end

   // scoreboard queues
   logic [14:0] fetch_q [$];
   logic [31:0] write_q [$];
   int          rd_run_q [$];
   int          wr_run_q [$];

   int total;
   int bad;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] ci(input logic a, input logic [5:0] c,
                                      input logic [2:0] d, input logic [2:0] j);
      return {3'b111, a, c, d, j};
   endfunction

   function automatic logic [15:0] ai(input int n);
      logic [14:0] v;
      v = n[14:0];
      return {1'b0, v};
   endfunction

   // monitor: pops expectations whenever the DUT presents a transaction
   int rd_len;
   int wr_len;
   initial begin
      rd_len = 0;
      wr_len = 0;
      forever begin
         @(negedge clock);
         if (readM && writeM) check("rw_exclusive", 32'd1, 32'd0);
         if (instr_req && instr_valid && fetch_q.size() > 0)
            check("fetch_pc", 32'(pc_), 32'(fetch_q.pop_front()));
         if (writeM && mem_ready) begin
            if (write_q.size() > 0)
               check("write_addr_data", {1'b0, addressM, outM}, write_q.pop_front());
            else
               check("unexpected_write", {1'b0, addressM, outM}, 32'hFFFF_FFFF);
         end
         if (readM) rd_len++;
         else if (rd_len > 0) begin
            if (rd_run_q.size() > 0) check("readM_cycles", 32'(rd_len), 32'(rd_run_q.pop_front()));
            else                     check("unexpected_read_run", 32'(rd_len), 32'd0);
            rd_len = 0;
         end
         if (writeM) wr_len++;
         else if (wr_len > 0) begin
            if (wr_run_q.size() > 0) check("writeM_cycles", 32'(wr_len), 32'(wr_run_q.pop_front()));
            else                     check("unexpected_write_run", 32'(wr_len), 32'd0);
            wr_len = 0;
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) begin
         rom[i] = 16'h0000;
         ram[i] = 16'h0000;
      end
   endtask

   // put the core in reset for two cycles; program loading happens after this
   task automatic enter_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic end_check(input string tag, input int cycles);
      repeat (cycles) @(negedge clock);
      check({tag, "_fetch_left"}, 32'(fetch_q.size()), 32'd0);
      check({tag, "_write_left"}, 32'(write_q.size()), 32'd0);
      check({tag, "_rdrun_left"}, 32'(rd_run_q.size()), 32'd0);
      check({tag, "_wrrun_left"}, 32'(wr_run_q.size()), 32'd0);
   endtask

   task automatic push_fetches(input int a[]);
      foreach (a[i]) fetch_q.push_back(a[i][14:0]);
   endtask

   initial begin
      int seen;
      total   = 0;
      bad     = 0;
      reset   = 1'b1;
      rd_wait = 0;
      wr_wait = 0;
      clear_mem();

      // T1: reset state; M=D at PC 0 exposes A=0 and D=0
      rom[0] = ci(1'b0, C_D, 3'b001, 3'b000);
      rom[1] = ai(1);
      rom[2] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
      push_fetches('{0, 1, 2, 1});
      write_q.push_back({1'b0, 15'd0, 16'd0});
      wr_run_q.push_back(1);
      repeat (2) @(negedge clock);
      check("rst_instr_req", 32'(instr_req), 32'd0);
      check("rst_readM", 32'(readM), 32'd0);
      check("rst_writeM", 32'(writeM), 32'd0);
      check("rst_outM", 32'(outM), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("rel_pc", 32'(pc_), 32'd0);
      check("rel_instr_req", 32'(instr_req), 32'd1);
      check("rel_readM", 32'(readM), 32'd0);
      check("rel_writeM", 32'(writeM), 32'd0);
`ifdef HACK_CPU_PERF_EN
      check("rel_instret", instret, 32'd0);
`endif
      end_check("t1", 30);

      // T2: @5; D=A; @7; D=D+A; @0; M=D
      enter_reset();
      clear_mem();
      rom[0] = ai(5);
      rom[1] = ci(1'b0, C_A, 3'b010, 3'b000);
      rom[2] = ai(7);
      rom[3] = ci(1'b0, C_DPA, 3'b010, 3'b000);
      rom[4] = ai(0);
      rom[5] = ci(1'b0, C_D, 3'b001, 3'b000);
      rom[6] = ai(6);
      rom[7] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
      push_fetches('{0, 1, 2, 3, 4, 5, 6, 7, 6, 7});
      write_q.push_back({1'b0, 15'd0, 16'd12});
      wr_run_q.push_back(1);
      reset = 1'b0;
      end_check("t2", 40);

      // T3: @3; M=M+1 with read wait 4, write wait 2
      enter_reset();
      clear_mem();
      ram[3] = 16'd41;
      rd_wait = 4;
      wr_wait = 2;
      rom[0] = ai(3);
      rom[1] = ci(1'b1, C_AP1, 3'b001, 3'b000);
      rom[2] = ai(2);
      rom[3] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
      push_fetches('{0, 1, 2, 3, 2});
      write_q.push_back({1'b0, 15'd3, 16'd42});
      rd_run_q.push_back(5);
      wr_run_q.push_back(3);
      reset = 1'b0;
      end_check("t3", 40);
      rd_wait = 0;
      wr_wait = 0;

      // T4: jumps JLT taken, JGT with D=0 not taken, JMP taken
      enter_reset();
      clear_mem();
      rom[0]  = ci(1'b0, C_M1, 3'b010, 3'b000);
      rom[1]  = ai(10);
      rom[2]  = ci(1'b0, C_D, 3'b000, 3'b100);
      rom[10] = ci(1'b0, C_ZERO, 3'b010, 3'b000);
      rom[11] = ai(20);
      rom[12] = ci(1'b0, C_D, 3'b000, 3'b001);
      rom[13] = ai(30);
      rom[14] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
      rom[30] = ai(30);
      rom[31] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
      push_fetches('{0, 1, 2, 10, 11, 12, 13, 14, 30, 31, 30});
      reset = 1'b0;
      end_check("t4", 40);

      // T5: @8; AM=M-1 with RAM[8]=1; then M=A+1 proves A became 0
      enter_reset();
      clear_mem();
      ram[8] = 16'd1;
      rom[0] = ai(8);
      rom[1] = ci(1'b1, C_AM1, 3'b101, 3'b000);
      rom[2] = ci(1'b0, C_AP1, 3'b001, 3'b000);
      rom[3] = ai(3);
      rom[4] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
      push_fetches('{0, 1, 2, 3, 4, 3});
      write_q.push_back({1'b0, 15'd8, 16'd0});
      write_q.push_back({1'b0, 15'd0, 16'd1});
      rd_run_q.push_back(1);
      wr_run_q.push_back(1);
      wr_run_q.push_back(1);
      reset = 1'b0;
      end_check("t5", 40);

      // T6: reset while AMD=D+1 waits on mem_ready for its write
      enter_reset();
      clear_mem();
      wr_wait = 100;
      rom[0] = ai(9);
      rom[1] = ci(1'b0, C_A, 3'b010, 3'b000);
      rom[2] = ai(4);
      rom[3] = ci(1'b0, C_DP1, 3'b111, 3'b000);
      rom[4] = ai(4);
      rom[5] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
      push_fetches('{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 4});
      write_q.push_back({1'b0, 15'd4, 16'd10});
      wr_run_q.push_back(3);
      wr_run_q.push_back(1);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 50 && seen == 0; i++) begin
         @(negedge clock);
         if (writeM) seen = 1;
      end
      check("t6_write_started", 32'(seen), 32'd1);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("t6_writeM_after_reset", 32'(writeM), 32'd0);
      check("t6_readM_after_reset", 32'(readM), 32'd0);
      check("t6_pc_after_reset", 32'(pc_), 32'd0);
`ifdef HACK_CPU_PERF_EN
      check("t6_instret", instret, 32'd0);
`endif
      wr_wait = 0;
      reset = 1'b0;
      end_check("t6", 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
